sng_frame_20: RTL and testbench
===============================

Name: sng_frame_20

Overview:
- Stochastic number generator stage that sits directly downstream of the 20-bit Fibonacci LFSR.
- Each cycle it consumes the LFSR's 20-bit random word and compares it against a loaded 20-bit probability value. It emits one stochastic bit per cycle for a frame of FRAME_LEN bits.
- A single-entry pending buffer with a valid/ready handshake allows back-to-back frames with no gap cycle.
- It reports the per-frame count of ones for downstream accumulation and checking.

Parameters:
- FRAME_LEN, 256: bits per frame; must be at least 2.
- CNT_W, $clog2(FRAME_LEN): width of the frame index counter.

Ports:
- CLK, input, 1: clock; all logic on posedge.
- RST, input, 1: synchronous, active-high reset.
- rand_in, input, 20: random word from the upstream LFSR; sampled every cycle.
- in_valid, input, 1: in_value is offered.
- in_ready, output, 1: pending buffer is empty; equals !pend_vld.
- in_value, input, 20: unsigned probability, p = in_value / 2^20.
- bit_out, output, 1: stochastic bit.
- bit_valid, output, 1: bit_out is meaningful this cycle.
- frame_done, output, 1: one-cycle pulse, coincident with the last bit of a frame.
- ones_count, output, CNT_W+1: number of ones in the frame just completed; valid while frame_done is high.
- busy, output, 1: state is RUN.

Behaviour:
- Reset (RST high at posedge):
  - state = IDLE; pend_vld = 0, so in_ready = 1.
  - cur_val = 0, cnt = 0, ones_acc = 0.
  - bit_out = 0, bit_valid = 0, frame_done = 0, ones_count = 0.
  - Reset mid-frame discards the frame and any pending value. No frame_done is issued.
- Handshake:
  - Accept when in_valid && in_ready; in_value goes into pend_val and pend_vld is set.
  - in_ready is registered state only; it has no combinational path from in_valid.
  - A value accepted in cycle N cannot be overwritten: in_ready stays low until the cycle after pend_val is consumed.
- IDLE:
  - If pend_vld: cur_val <= pend_val, pend_vld <= 0, cnt <= 0, ones_acc <= 0, go to RUN.
  - Otherwise remain in IDLE with bit_valid = 0.
- RUN, every cycle:
  - cmp = (cur_val == 20'hFFFFF) ? 1 : (rand_in < cur_val), unsigned compare.
    - All-ones saturates to probability 1.
    - A value of 0 gives probability 0.
  - bit_out <= cmp, bit_valid <= 1, ones_acc <= ones_acc + cmp, cnt <= cnt + 1.
- Latency:
  - The bit for the rand_in sampled in cycle k appears on bit_out in cycle k+1.
  - The first bit_valid occurs 2 cycles after the handshake cycle: handshake, then IDLE load, then first compare registered.
- Frame end (RUN with cnt == FRAME_LEN-1):
  - Next cycle: frame_done = 1 and ones_count = ones_acc + cmp, i.e. the full frame total including the last bit.
  - If pend_vld: reload cur_val, clear pend_vld, cnt <= 0, ones_acc <= 0, stay in RUN. The next frame's first bit follows the last bit with no gap.
  - Otherwise go to IDLE; bit_valid drops one cycle after frame_done.
- Simultaneous accept and reload in the same cycle cannot happen, because in_ready = !pend_vld.
- ones_count holds its value between frame_done pulses.
- ones_count maximum is FRAME_LEN, hence the CNT_W+1 width. It never wraps.
- rand_in is consumed every RUN cycle regardless of downstream state. There is no backpressure on bit_out.

Decomposition:
- Package sc_pkg holds:
  - typedef sc_word_t (logic [19:0])
  - enum sng_state_t {IDLE, RUN}
  - localparam SC_ONE = 20'hFFFFF
- Optional sub-module sc_comparator_20: the combinational saturating compare (cur_val, rand_in -> cmp). It is reused by other SNG variants.
- The FSM, counters and pending buffer stay in sng_frame_20.

Test Plan:
- Reset then load 0x80000 with FRAME_LEN=4 and rand_in = 0x7FFFF, 0x80000, 0x00000, 0xFFFFF -> bit_out 1,0,1,0 starting 2 cycles after the handshake. frame_done pulses with the 4th bit; ones_count = 2; then IDLE.
- Load 0x00000, random rand_in over a full frame of 256 -> all bits 0, ones_count = 0.
- Load 0xFFFFF with rand_in held at 0xFFFFF -> all bits 1, ones_count = 256 (no wrap).
- Back-to-back, FRAME_LEN=4:
  - Load 0x40000 and, while busy, load 0xC0000; in_ready goes low after the second accept.
  - Frame 2 bits follow frame 1 with zero gap; frame_done fires twice, 4 cycles apart.
  - in_ready returns to 1 on the cycle after the reload.
- Assert RST at cnt=2 mid-frame with a value pending -> next cycle all outputs 0, in_ready = 1, no frame_done. A fresh load restarts at cnt=0.
- Drive LFSR-driven statistics (fibonacci_lfsr_20 into rand_in), in_value = 0x40000, 64 frames of 256 -> mean ones_count within 64 ± 8.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared types and constants for the 20-bit stochastic number generators.
package sc_pkg;
    typedef logic [19:0] sc_word_t;
    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} sng_state_t;
    localparam sc_word_t SC_ONE = 20'hFFFFF;
endpackage

// File: rtl/sc_comparator_20.sv
// Saturating probability compare: an all-ones probability always yields 1.
module sc_comparator_20
    import sc_pkg::*;
(
    input  logic [19:0] cur_val_i,
    input  logic [19:0] rand_i,
    output logic        cmp_o
);
    assign cmp_o = (cur_val_i == SC_ONE) ? 1'b1 : (rand_i < cur_val_i);
endmodule

// File: rtl/sng_frame_20.sv
// Framed stochastic bit generator with a single-entry pending probability buffer
// so consecutive frames run without a gap cycle.
module sng_frame_20
    import sc_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int CNT_W     = $clog2(FRAME_LEN)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [19:0]      rand_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [19:0]      in_value,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             frame_done,
    output logic [CNT_W:0]   ones_count,
    output logic             busy
);
    sng_state_t       state_q, state_d;
    sc_word_t         pend_val_q, pend_val_d;
    sc_word_t         cur_val_q, cur_val_d;
    logic             pend_vld_q, pend_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   ones_acc_q, ones_acc_d;
    logic [CNT_W:0]   ones_count_q, ones_count_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             cmp, accept, last;

    sc_comparator_20 u_cmp (
        .cur_val_i (cur_val_q),
        .rand_i    (rand_in),
        .cmp_o     (cmp)
    );

    // Accept and consume are mutually exclusive: one needs pend_vld low, the other high.
    assign accept = in_valid && !pend_vld_q;
    assign last   = (cnt_q == CNT_W'(FRAME_LEN - 1));

    always_comb begin
        state_d      = state_q;
        pend_val_d   = pend_val_q;
        pend_vld_d   = pend_vld_q;
        cur_val_d    = cur_val_q;
        cnt_d        = cnt_q;
        ones_acc_d   = ones_acc_q;
        ones_count_d = ones_count_q;
        bit_out_d    = 1'b0;
        bit_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (accept) begin
            pend_val_d = in_value;
            pend_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pend_vld_q) begin
                    cur_val_d  = pend_val_q;
                    pend_vld_d = 1'b0;
                    cnt_d      = '0;
                    ones_acc_d = '0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                bit_out_d   = cmp;
                bit_valid_d = 1'b1;
                cnt_d       = cnt_q + CNT_W'(1);
                ones_acc_d  = ones_acc_q + (CNT_W+1)'(cmp);
                if (last) begin
                    frame_done_d = 1'b1;
                    ones_count_d = ones_acc_q + (CNT_W+1)'(cmp);
                    cnt_d        = '0;
                    ones_acc_d   = '0;
                    if (pend_vld_q) begin
                        cur_val_d  = pend_val_q;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            pend_val_q   <= '0;
            pend_vld_q   <= 1'b0;
            cur_val_q    <= '0;
            cnt_q        <= '0;
            ones_acc_q   <= '0;
            ones_count_q <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_val_q   <= pend_val_d;
            pend_vld_q   <= pend_vld_d;
            cur_val_q    <= cur_val_d;
            cnt_q        <= cnt_d;
            ones_acc_q   <= ones_acc_d;
            ones_count_q <= ones_count_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign in_ready   = !pend_vld_q;
    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign frame_done = frame_done_q;
    assign ones_count = ones_count_q;
    assign busy       = (state_q == RUN);
endmodule

// File: tb/tb_sng_frame_20.sv
// Directed bench: a FRAME_LEN=4 instance for timing/handshake cases and a
// FRAME_LEN=256 instance for full-frame and statistical cases.
module tb_sng_frame_20;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic [19:0] a_rand, a_value;
    logic        a_valid, a_ready, a_bit, a_bvld, a_done, a_busy;
    logic [2:0]  a_ones;
    logic [19:0] b_rand, b_value;
    logic        b_valid, b_ready, b_bit, b_bvld, b_done, b_busy;
    logic [8:0]  b_ones;
    logic [19:0] b_lfsr;

    int errors = 0;
    int checks = 0;

    sng_frame_20 #(.FRAME_LEN(4)) dut_a (
        .CLK(CLK), .RST(RST), .rand_in(a_rand), .in_valid(a_valid), .in_ready(a_ready),
        .in_value(a_value), .bit_out(a_bit), .bit_valid(a_bvld), .frame_done(a_done),
        .ones_count(a_ones), .busy(a_busy)
    );

    sng_frame_20 #(.FRAME_LEN(256)) dut_b (
        .CLK(CLK), .RST(RST), .rand_in(b_rand), .in_valid(b_valid), .in_ready(b_ready),
        .in_value(b_value), .bit_out(b_bit), .bit_valid(b_bvld), .frame_done(b_done),
        .ones_count(b_ones), .busy(b_busy)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        a_valid = 1'b0; a_value = '0; a_rand = '0;
        b_valid = 1'b0; b_value = '0; b_rand = '0;
        tick(); tick();
        checks++;
        if ({a_ready, a_busy, a_bit, a_bvld, a_done, a_ones} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_a: got rdy/busy/bit/vld/done/ones=%b want 10000000",
                     {a_ready, a_busy, a_bit, a_bvld, a_done, a_ones});
        end
        checks++;
        if ({b_ready, b_busy, b_bit, b_bvld, b_done, b_ones} !== 14'b10_0000_0000_0000) begin
            errors++;
            $display("FAIL reset_b: got rdy/busy/bit/vld/done/ones=%b want 1 followed by zeros",
                     {b_ready, b_busy, b_bit, b_bvld, b_done, b_ones});
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        logic [19:0] r [4];
        logic        eb [4];
        r  = '{20'h7FFFF, 20'h80000, 20'h00000, 20'hFFFFF};
        eb = '{1'b1, 1'b0, 1'b1, 1'b0};
        a_valid = 1'b1; a_value = 20'h80000;
        tick();
        a_valid = 1'b0;
        checks++;
        if (a_ready !== 1'b0 || a_bvld !== 1'b0) begin
            errors++;
            $display("FAIL basic_accept: got ready=%b vld=%b want 0 0", a_ready, a_bvld);
        end
        a_rand = r[0];
        tick();
        checks++;
        if (a_busy !== 1'b1 || a_bvld !== 1'b0) begin
            errors++;
            $display("FAIL basic_load: got busy=%b vld=%b want 1 0", a_busy, a_bvld);
        end
        for (int i = 0; i < 4; i++) begin
            a_rand = r[i];
            tick();
            checks++;
            if ({a_bvld, a_bit, a_done} !== {1'b1, eb[i], (i == 3)}) begin
                errors++;
                $display("FAIL basic_bit%0d: got vld/bit/done=%b want %b", i,
                         {a_bvld, a_bit, a_done}, {1'b1, eb[i], (i == 3)});
            end
        end
        checks++;
        if (a_ones !== 3'd2) begin
            errors++;
            $display("FAIL basic_ones: got %0d want 2", a_ones);
        end
        tick();
        checks++;
        if ({a_bvld, a_done, a_busy} !== 3'b000 || a_ones !== 3'd2) begin
            errors++;
            $display("FAIL basic_idle: got vld/done/busy=%b ones=%0d want 000 ones=2",
                     {a_bvld, a_done, a_busy}, a_ones);
        end
    endtask

    task automatic test_back_to_back();
        logic ev, eb, ed;
        a_rand = 20'h80000;
        a_valid = 1'b1; a_value = 20'h40000;
        tick();
        a_valid = 1'b0;
        checks++;
        if (a_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_low1: got %b want 0", a_ready);
        end
        tick();
        checks++;
        if (a_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_after_load: got %b want 1", a_ready);
        end
        a_valid = 1'b1; a_value = 20'hC0000;
        tick();
        a_valid = 1'b0;
        checks++;
        if (a_ready !== 1'b0 || {a_bvld, a_bit} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_second_accept: got ready=%b vld/bit=%b want 0 10", a_ready, {a_bvld, a_bit});
        end
        for (int c = 3; c <= 10; c++) begin
            tick();
            ev = (c <= 9);
            eb = (c >= 6 && c <= 9);
            ed = (c == 5 || c == 9);
            checks++;
            if ({a_bvld, a_bit, a_done} !== {ev, eb, ed}) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got vld/bit/done=%b want %b", c,
                         {a_bvld, a_bit, a_done}, {ev, eb, ed});
            end
            if (c == 5) begin
                checks++;
                if (a_ones !== 3'd0 || a_ready !== 1'b1 || a_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_frame1_end: got ones=%0d ready=%b busy=%b want 0 1 1",
                             a_ones, a_ready, a_busy);
                end
            end
            if (c == 9) begin
                checks++;
                if (a_ones !== 3'd4) begin
                    errors++;
                    $display("FAIL b2b_frame2_ones: got %0d want 4", a_ones);
                end
            end
        end
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy=%b want 0", a_busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        a_rand = 20'h00000;
        a_valid = 1'b1; a_value = 20'h80000;
        tick();
        a_valid = 1'b0;
        tick();
        a_valid = 1'b1; a_value = 20'h10000;
        tick();
        a_valid = 1'b0;
        tick();
        checks++;
        if ({a_bvld, a_bit, a_ready, a_done} !== 4'b1100) begin
            errors++;
            $display("FAIL rstmid_pre: got vld/bit/rdy/done=%b want 1100", {a_bvld, a_bit, a_ready, a_done});
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if ({a_ready, a_busy, a_bit, a_bvld, a_done, a_ones} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL rstmid_post: got rdy/busy/bit/vld/done/ones=%b want 10000000",
                     {a_ready, a_busy, a_bit, a_bvld, a_done, a_ones});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({a_bvld, a_done, a_busy} !== 3'b000) begin
                errors++;
                $display("FAIL rstmid_discard%0d: got vld/done/busy=%b want 000", i, {a_bvld, a_done, a_busy});
            end
        end
        a_rand = 20'hFFFFF;
        a_valid = 1'b1; a_value = 20'hFFFFF;
        tick();
        a_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({a_bvld, a_bit, a_done} !== {2'b11, (i == 3)}) begin
                errors++;
                $display("FAIL rstmid_reload_bit%0d: got vld/bit/done=%b want %b", i,
                         {a_bvld, a_bit, a_done}, {2'b11, (i == 3)});
            end
        end
        checks++;
        if (a_ones !== 3'd4) begin
            errors++;
            $display("FAIL rstmid_reload_ones: got %0d want 4", a_ones);
        end
        tick();
    endtask

    // mode 0: $urandom, 1: held at all-ones, otherwise: bench LFSR
    task automatic run_b(input logic [19:0] val, input int mode, output int nbits,
                         output int nones, output int cnt_out, output bit timeout);
        nbits = 0; nones = 0; cnt_out = -1; timeout = 1'b1;
        b_valid = 1'b1; b_value = val;
        tick();
        b_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            case (mode)
                0:       b_rand = 20'($urandom());
                1:       b_rand = 20'hFFFFF;
                default: begin
                    b_rand = b_lfsr;
                    b_lfsr = {b_lfsr[18:0], b_lfsr[19] ^ b_lfsr[16]};
                end
            endcase
            tick();
            if (b_bvld) begin
                nbits++;
                if (b_bit) nones++;
            end
            if (b_done) begin
                cnt_out = int'(b_ones);
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_zero_prob();
        int nb, no, co;
        bit to;
        run_b(20'h00000, 0, nb, no, co, to);
        checks++;
        if (to || nb != 256 || no != 0 || co != 0) begin
            errors++;
            $display("FAIL zero_prob: got timeout=%0d bits=%0d ones=%0d count=%0d want 0 256 0 0", to, nb, no, co);
        end
        tick();
        checks++;
        if ({b_bvld, b_busy} !== 2'b00) begin
            errors++;
            $display("FAIL zero_idle: got vld/busy=%b want 00", {b_bvld, b_busy});
        end
    endtask

    task automatic test_saturate();
        int nb, no, co;
        bit to;
        run_b(20'hFFFFF, 1, nb, no, co, to);
        checks++;
        if (to || nb != 256 || no != 256 || co != 256) begin
            errors++;
            $display("FAIL saturate: got timeout=%0d bits=%0d ones=%0d count=%0d want 0 256 256 256", to, nb, no, co);
        end
        tick();
    endtask

    task automatic test_lfsr_stats();
        int nb, no, co, sum, bad;
        bit to;
        sum = 0; bad = 0;
        b_lfsr = 20'h00001;
        for (int f = 0; f < 64; f++) begin
            run_b(20'h40000, 2, nb, no, co, to);
            if (to || nb != 256 || no != co) bad++;
            sum += co;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL lfsr_frames: got %0d inconsistent frames want 0", bad);
        end
        checks++;
        if (sum < 56 * 64 || sum > 72 * 64) begin
            errors++;
            $display("FAIL lfsr_mean: got total=%0d (mean %0d) want mean within 64+-8", sum, sum / 64);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_reset_mid_frame();
        test_zero_prob();
        test_saturate();
        test_lfsr_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
